// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory request/response channel,
// the decode-side instruction handshake and the branch-unit redirect inputs
// of the fetch stage into one bundle.
// The master modport is the fetch unit's view.
// The slave modport is the view of the environment (memory, decode and branch unit).
interface fetch_unit_if;
  logic        taken;
  logic        jump;
  logic [31:0] target;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;

  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    input  taken,
    input  jump,
    input  target,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    output taken,
    output jump,
    output target,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// FetchUnit: instruction-fetch stage.
// It owns the PC and keeps exactly one instruction-memory request in flight.
// It holds each fetched word for decode until decode accepts it.
// The next PC is chosen in the acceptance cycle: the branch-unit target on a
// redirect, otherwise pc + 4.
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_req_valid;
  logic        r_instr_valid;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;

  // Choose the PC that follows the presented instruction (used only on acceptance)
  always_comb begin
    w_redirect    = bus.taken | bus.jump;
    w_redirect_pc = {bus.target[31:2], 2'b00};
    w_seq_pc      = r_pc + 32'd4;
    w_next_pc     = w_redirect ? w_redirect_pc : w_seq_pc;
  end

  // Fetch FSM with registered handshake outputs; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state     <= REQ;
          r_req_valid <= 1'b1;
        end

        REQ: begin
          if (bus.imem_req_ready) begin
            r_state     <= WAIT;
            r_req_valid <= 1'b0;
          end
        end

        WAIT: begin
          if (bus.imem_rsp_valid) begin
            r_state       <= OUT;
            r_instr       <= bus.imem_rsp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
          end
        end

        OUT: begin
          if (bus.instr_ready) begin
            r_state       <= REQ;
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b1;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_req_valid   <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr_valid    = r_instr_valid;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The bench contains a behavioural memory with configurable accept and response
// timing, and a transaction-level PC model.
// Directed sequences and a table of redirect vectors run first, followed by a
// randomized run.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        jump;
    logic [31:0] target;
    logic [31:0] nextAddr;
  } vec_t;

  logic clk;
  logic rst;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks;
  int          errors;
  int          readyMode;
  int          instrReadyMode;
  int          strayMode;
  int          latency;
  bit          randomMode;
  int          rstHold;
  bit          pending;
  int          countdown;
  logic [31:0] pendAddr;
  logic [31:0] modelPc;
  bit          holdFlag;
  logic [31:0] holdInstr;
  logic [31:0] holdPc;
  int          acceptCount;
  int          cycleIdx;
  vec_t        vecs[9];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr | 32'h1000_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycleIdx);
    end
  endtask

  // One clock cycle: model bookkeeping and invariant checks before the edge,
  // memory bookkeeping at the edge, then the inputs for the next cycle are driven.
  task automatic applyStimulus();
    bit          reqFire;
    bit          rspFire;
    bit          accFire;
    logic [31:0] addrPre;
    #1;
    if (rst) begin
      pending  = 1'b0;
      modelPc  = RESET_PC;
      holdFlag = 1'b0;
    end
    if (holdFlag) begin
      checkOutput("hold_valid", bus.instr_valid, 1);
      checkOutput("hold_instr", bus.instr, holdInstr);
      checkOutput("hold_pc", bus.instr_pc, holdPc);
    end
    checkOutput("addr_is_pc", bus.imem_addr, modelPc);
    if (!rst && bus.imem_req_valid)
      checkOutput("one_outstanding", {30'b0, pending, bus.instr_valid}, 0);
    addrPre   = bus.imem_addr;
    reqFire   = !rst && bus.imem_req_valid && bus.imem_req_ready;
    rspFire   = !rst && bus.imem_rsp_valid && pending && (countdown == 0);
    accFire   = !rst && bus.instr_valid && bus.instr_ready;
    holdFlag  = !rst && bus.instr_valid && !bus.instr_ready;
    holdInstr = bus.instr;
    holdPc    = bus.instr_pc;
    if (accFire) begin
      checkOutput("acc_pc", bus.instr_pc, modelPc);
      checkOutput("acc_instr", bus.instr, memData(modelPc));
      if (bus.taken || bus.jump) modelPc = bus.target & 32'hFFFF_FFFC;
      else                       modelPc = modelPc + 32'd4;
      acceptCount++;
    end
    @(posedge clk);
    if (rspFire) pending = 1'b0;
    else if (pending && countdown > 0) countdown--;
    if (reqFire) begin
      pending   = 1'b1;
      pendAddr  = addrPre;
      countdown = latency - 1;
    end
    #1;
    cycleIdx++;
    if (randomMode) begin
      if (rstHold > 0) begin
        rstHold--;
        if (rstHold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst     = 1'b1;
        rstHold = int'($urandom_range(1, 2));
      end
      bus.taken  = ($urandom_range(0, 3) == 0);
      bus.jump   = ($urandom_range(0, 7) == 0);
      bus.target = $urandom;
      latency    = int'($urandom_range(1, 3));
    end
    if (rst) pending = 1'b0;
    case (readyMode)
      0:       bus.imem_req_ready = 1'b1;
      1:       bus.imem_req_ready = 1'b0;
      default: bus.imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    case (instrReadyMode)
      0:       bus.instr_ready = 1'b1;
      1:       bus.instr_ready = 1'b0;
      default: bus.instr_ready = 1'($urandom_range(0, 1));
    endcase
    if (pending && countdown == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memData(pendAddr);
    end else if (!pending && (strayMode == 1 || (strayMode == 2 && $urandom_range(0, 3) == 0))) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = JUNK;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  // Advance until a request (kind 0) or a presented instruction (kind 1) at addr appears
  task automatic waitFor(input int kind, input logic [31:0] addr, input string name);
    int n;
    bit hit;
    n   = 0;
    hit = (kind == 0) ? (bus.imem_req_valid && bus.imem_addr == addr)
                      : (bus.instr_valid && bus.instr_pc == addr);
    while (!hit && n < 40) begin
      applyStimulus();
      n++;
      hit = (kind == 0) ? (bus.imem_req_valid && bus.imem_addr == addr)
                        : (bus.instr_valid && bus.instr_pc == addr);
    end
    checkOutput(name, hit, 1);
  endtask

  // Main test sequence
  initial begin
    int validK[$];
    logic [31:0] validPc[$];
    int startAccepts;

    checks = 0; errors = 0; cycleIdx = 0; acceptCount = 0;
    readyMode = 0; instrReadyMode = 0; strayMode = 0; latency = 1;
    randomMode = 1'b0; rstHold = 0; pending = 1'b0; countdown = 0;
    pendAddr = '0; modelPc = RESET_PC; holdFlag = 1'b0;
    holdInstr = '0; holdPc = '0;
    bus.taken = 1'b0; bus.jump = 1'b0; bus.target = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b1;

    vecs[0] = '{pc: 32'h10,        taken: 1'b1, jump: 1'b0, target: 32'h40,        nextAddr: 32'h40};
    vecs[1] = '{pc: 32'h40,        taken: 1'b1, jump: 1'b0, target: 32'h10,        nextAddr: 32'h10};
    vecs[2] = '{pc: 32'h10,        taken: 1'b0, jump: 1'b0, target: 32'h80,        nextAddr: 32'h14};
    vecs[3] = '{pc: 32'h14,        taken: 1'b0, jump: 1'b1, target: 32'h12,        nextAddr: 32'h10};
    vecs[4] = '{pc: 32'h10,        taken: 1'b0, jump: 1'b1, target: 32'h103,       nextAddr: 32'h100};
    vecs[5] = '{pc: 32'h100,       taken: 1'b1, jump: 1'b1, target: 32'h204,       nextAddr: 32'h204};
    vecs[6] = '{pc: 32'h204,       taken: 1'b0, jump: 1'b0, target: 32'hFFFF_FFFC, nextAddr: 32'h208};
    vecs[7] = '{pc: 32'h208,       taken: 1'b0, jump: 1'b1, target: 32'hFFFF_FFFF, nextAddr: 32'hFFFF_FFFC};
    vecs[8] = '{pc: 32'hFFFF_FFFC, taken: 1'b0, jump: 1'b0, target: 32'h0,         nextAddr: 32'h0};

    rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("rst_req_valid", bus.imem_req_valid, 0);
    checkOutput("rst_instr_valid", bus.instr_valid, 0);
    checkOutput("rst_instr", bus.instr, NOP);
    checkOutput("rst_instr_pc", bus.instr_pc, RESET_PC);
    checkOutput("rst_addr", bus.imem_addr, RESET_PC);

    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus();
      if (k == 1) checkOutput("first_req", bus.imem_req_valid, 1);
      if (bus.instr_valid) begin
        validK.push_back(k);
        validPc.push_back(bus.instr_pc);
      end
    end
    checkOutput("pulse_count", validK.size(), 3);
    for (int i = 0; i < validK.size() && i < 3; i++) begin
      checkOutput("pulse_cycle", validK[i], 3 * (i + 1));
      checkOutput("pulse_pc", validPc[i], 4 * i);
    end

    waitFor(0, 32'h10, "reach_req_10");
    readyMode = 1;
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("stall_req_valid", bus.imem_req_valid, 1);
      checkOutput("stall_addr", bus.imem_addr, 32'h10);
    end
    readyMode = 0;
    instrReadyMode = 1;
    bus.imem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("req_accepted", bus.imem_req_valid, 0);

    waitFor(1, 32'h10, "reach_out_10");
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("out_stall_valid", bus.instr_valid, 1);
      checkOutput("out_stall_instr", bus.instr, 32'h1000_0010);
      checkOutput("out_stall_pc", bus.instr_pc, 32'h10);
      checkOutput("out_stall_noreq", bus.imem_req_valid, 0);
    end

    foreach (vecs[i]) begin
      waitFor(1, vecs[i].pc, "vec_reach");
      checkOutput("vec_instr", bus.instr, memData(vecs[i].pc));
      bus.taken       = vecs[i].taken;
      bus.jump        = vecs[i].jump;
      bus.target      = vecs[i].target;
      bus.instr_ready = 1'b1;
      applyStimulus();
      bus.taken  = 1'b0;
      bus.jump   = 1'b0;
      bus.target = '0;
      checkOutput("vec_next_addr", bus.imem_addr, vecs[i].nextAddr);
      checkOutput("vec_next_req", bus.imem_req_valid, 1);
    end

    readyMode = 1;
    strayMode = 1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = JUNK;
    bus.taken  = 1'b1;
    bus.jump   = 1'b1;
    bus.target = 32'h80;
    bus.instr_ready = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("stray_instr", bus.instr, memData(32'hFFFF_FFFC));
    checkOutput("stray_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    checkOutput("stray_pc", bus.imem_addr, 32'h0);
    readyMode = 0;
    bus.imem_req_ready = 1'b1;
    applyStimulus();
    strayMode = 0;
    waitFor(1, 32'h0, "stray_reach_out");
    checkOutput("stray_captured", bus.instr, memData(32'h0));
    bus.taken = 1'b0;
    bus.jump  = 1'b0;
    bus.instr_ready = 1'b1;
    applyStimulus();
    checkOutput("stray_next_addr", bus.imem_addr, 32'h4);

    waitFor(1, 32'h4, "reach_out_4");
    bus.jump   = 1'b1;
    bus.target = 32'h20;
    bus.instr_ready = 1'b1;
    applyStimulus();
    bus.jump   = 1'b0;
    bus.target = '0;
    latency = 3;
    waitFor(0, 32'h20, "reach_req_20");
    applyStimulus();
    checkOutput("in_wait", bus.imem_req_valid | bus.instr_valid, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req_valid", bus.imem_req_valid, 0);
    checkOutput("midrst_instr_valid", bus.instr_valid, 0);
    checkOutput("midrst_addr", bus.imem_addr, RESET_PC);
    checkOutput("midrst_instr", bus.instr, NOP);
    checkOutput("midrst_instr_pc", bus.instr_pc, RESET_PC);
    repeat (2) applyStimulus();
    rst = 1'b0;
    latency = 1;
    instrReadyMode = 0;
    waitFor(0, RESET_PC, "restart_req");
    waitFor(1, RESET_PC, "restart_out");
    checkOutput("restart_instr", bus.instr, memData(RESET_PC));

    randomMode = 1'b1;
    readyMode = 2;
    instrReadyMode = 2;
    strayMode = 2;
    startAccepts = acceptCount;
    repeat (3000) applyStimulus();
    checkOutput("random_progress", (acceptCount - startAccepts) > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and presents each fetched instruction to decode. It is the direct consumer of the branch unit's `taken` output. When decode accepts an instruction whose branch or jump resolves as redirecting, the next fetch goes to `target`; otherwise it goes to `pc + 4`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `taken`  in  1: branch-unit decision for the instruction currently on `instr`.
- `jump`  in  1: unconditional redirect (jal/jalr) for the instruction currently on `instr`.
- `target`  in  32: redirect address for the presented instruction.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_addr`  out  32: fetch address; always equal to the PC register.
- `imem_rsp_valid`  in  1: response data valid.
- `imem_rsp_data`  in  32: fetched instruction word.
- `instr_valid`  out  1: `instr` and `instr_pc` are valid for decode.
- `instr_ready`  in  1: decode accepts the instruction.
- `instr`  out  32: held instruction word.
- `instr_pc`  out  32: address of `instr`.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, OUT. The reset state is IDLE.
- IDLE -> REQ unconditionally, one cycle after `rst` deasserts.
- REQ:
  - `imem_req_valid` = 1 and `imem_addr` = pc.
  - When `imem_req_ready` = 1, go to WAIT.
  - `imem_addr` must stay stable while the request waits for `imem_req_ready`.
- WAIT:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: capture `instr` <= `imem_rsp_data`, capture `instr_pc` <= pc, then go to OUT.
- OUT:
  - `instr_valid` = 1.
  - `instr` and `instr_pc` hold stable until the cycle in which `instr_ready` = 1.
  - On acceptance, go to REQ.
  - In the acceptance cycle, if `taken | jump`: pc <= {target[31:2], 2'b00}. Otherwise pc <= pc + 4.
- `taken`, `jump` and `target` are sampled only in the OUT-state acceptance cycle. They are ignored in every other cycle.
- `imem_rsp_valid` is ignored outside WAIT. Memory latency is at least one cycle after request acceptance; a response in the same cycle as `imem_req_ready` is not captured.
- Exactly one request is outstanding at any time. There is no prefetch and no speculative fetch.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- If `taken` and `jump` are both 1, a single redirect to `target` occurs.

## Timing
- Reset values (asynchronous):
  - state = IDLE, pc = RESET_PC, `imem_addr` = RESET_PC.
  - `imem_req_valid` = 0, `instr_valid` = 0.
  - `instr` = 32'h0000_0013 (nop), `instr_pc` = RESET_PC.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
- First request: `imem_req_valid` rises in the second cycle after `rst` falls (IDLE occupies one cycle).
- Steady-state throughput, with a memory that accepts immediately, one-cycle response latency and decode always ready: 3 cycles per instruction (REQ, WAIT, OUT).
- A redirect takes effect on the very next request. The redirect penalty is zero, because nothing was fetched speculatively.
- Reset asserted mid-operation, in any state:
  - Immediate return to the reset values.
  - Any outstanding response is dropped; memory must also be reset by the same `rst`.

## Test plan
- Reset release, with memory returning addr|32'h1000_0000 one cycle after acceptance and decode always ready -> `instr_pc` sequence 0x0, 0x4, 0x8; each `instr_valid` pulse lasts 1 cycle, spaced every 3 cycles.
- `imem_req_ready` held low for 4 cycles in REQ -> `imem_req_valid` stays 1 with `imem_addr` stable for 5 cycles; no state advance.
- `instr_ready` low for 3 cycles in OUT -> `instr`/`instr_pc` stable; no new request issued until acceptance.
- Accept instr at pc 0x10 with `taken`=1, `target`=0x40 -> next `imem_addr` = 0x40. Repeat with `taken`=0 -> next `imem_addr` = 0x14. Repeat with `jump`=1, `target`=0x103 -> next `imem_addr` = 0x100.
- `taken`=1 while `instr_valid`=0, and stray `imem_rsp_valid` in REQ -> no effect on pc or `instr`.
- `rst` pulsed while in WAIT at pc 0x20 -> same cycle: `imem_req_valid`=0, `instr_valid`=0, pc = RESET_PC; after release, fetch restarts at RESET_PC.
